// File: rtl/mem_port_arbiter_if.sv
// Bundle between the fetch/load-store requesters, the shared memory port and the arbiter.
// Latency: none, wires only.
// Backpressure: requesters hold req until their done pulse; the memory stalls with mem_ready.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Requester side
  logic              req0;
  logic [ADDR_W-1:0] addr0;
  logic              req1;
  logic [ADDR_W-1:0] addr1;
  logic              we1;
  logic [DATA_W-1:0] wd1;
  // Memory side
  logic [DATA_W-1:0] mem_rd;
  logic              mem_ready;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wd;
  // Arbiter results
  logic              sel;
  logic [DATA_W-1:0] rd;
  logic              done0;
  logic              done1;

  // Arbiter view
  modport slave (
    input  req0, addr0, req1, addr1, we1, wd1, mem_rd, mem_ready,
    output mem_en, mem_we, mem_addr, mem_wd, sel, rd, done0, done1
  );

  // Requester/memory view
  modport master (
    output req0, addr0, req1, addr1, we1, wd1, mem_rd, mem_ready,
    input  mem_en, mem_we, mem_addr, mem_wd, sel, rd, done0, done1
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter/sequencer for the shared memory port (fetch = port 0, load/store = port 1).
// Latency: grant to mem_en 1 cycle; mem_ready to done/rd 1 cycle; 3 cycles minimum per access.
// Backpressure: losing requester waits with req held; memory stalls the access by holding mem_ready low.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q;
  logic              sel_q;     // mux select, frozen from grant until the next grant
  logic              last_q;    // most recently granted port, breaks ties
  logic              mem_en_q;
  logic              done0_q;
  logic              done1_q;
  logic [DATA_W-1:0] rd_q;

  logic              any_req;
  logic              grant_port;
  logic [ADDR_W-1:0] addr_mux;

  // Pick the winner for an IDLE-cycle grant: a lone requester wins, a tie goes to the port not served last.
  always_comb begin
    any_req = bus.req0 | bus.req1;
    if (bus.req0 && bus.req1) begin
      grant_port = ~last_q;
    end else begin
      grant_port = bus.req1;
    end
  end

  // Access sequencer: IDLE grants, BUSY waits on the memory, DONE pulses the winner's done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sel_q    <= 1'b0;
      last_q   <= 1'b1;   // fetch wins the first tie
      mem_en_q <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      rd_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done0_q <= 1'b0;
          done1_q <= 1'b0;
          if (any_req) begin
            sel_q    <= grant_port;
            last_q   <= grant_port;
            mem_en_q <= 1'b1;
            state_q  <= BUSY;
          end
        end
        BUSY: begin
          // Read data is captured on stores too; the requester simply ignores it.
          if (bus.mem_ready) begin
            rd_q     <= bus.mem_rd;
            mem_en_q <= 1'b0;
            done0_q  <= ~sel_q;
            done1_q  <= sel_q;
            state_q  <= DONE;
          end
        end
        DONE: begin
          // Requests raised during BUSY/DONE are only considered from the next IDLE cycle.
          done0_q <= 1'b0;
          done1_q <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          mem_en_q <= 1'b0;
          done0_q  <= 1'b0;
          done1_q  <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  // Address/data muxes in front of the memory follow the registered select.
  always_comb begin
    addr_mux = sel_q ? bus.addr1 : bus.addr0;
  end

  assign bus.mem_en   = mem_en_q;
  assign bus.mem_we   = mem_en_q & sel_q & bus.we1;
  assign bus.mem_addr = addr_mux;
  assign bus.mem_wd   = bus.wd1;
  assign bus.sel      = sel_q;
  assign bus.rd       = rd_q;
  assign bus.done0    = done0_q;
  assign bus.done1    = done1_q;

  // Completion pulses are exclusive.
  a_done_onehot: assert property (@(posedge clk) disable iff (rst) !(done0_q && done1_q));
  // Fetch never writes memory.
  a_we_data_only: assert property (@(posedge clk) disable iff (rst) bus.mem_we |-> sel_q);
  // The port is enabled for the whole of every access.
  a_busy_en: assert property (@(posedge clk) disable iff (rst) (state_q == BUSY) |-> mem_en_q);

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter and sequencer for the single shared memory port in the MIPS datapath. It arbitrates between the instruction-fetch requester (port 0) and the load/store requester (port 1). It drives the select of the 2:1 address/write-data muxes in front of the memory and sequences each access with a req/done handshake. It routes read data back to the winner. The block sits between the fetch/MEM logic and the memory, and replaces hard-wired mux selects with a registered, arbitrated select.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-high
- req0  in  1  fetch request, held until done0
- addr0  in  ADDR_W  fetch address, stable while req0 high
- req1  in  1  data request, held until done1
- addr1  in  ADDR_W  data address, stable while req1 high
- we1  in  1  data write enable (1 = store)
- wd1  in  DATA_W  store data
- mem_rd  in  DATA_W  memory read data, valid with mem_ready
- mem_ready  in  1  memory completes the current access this cycle
- mem_en  out  1  memory access active
- mem_we  out  1  write strobe = mem_en & sel & we1
- mem_addr  out  ADDR_W  sel ? addr1 : addr0 (combinational from registered sel)
- mem_wd  out  DATA_W  wd1
- sel  out  1  registered mux select; 0 = fetch, 1 = data
- rd  out  DATA_W  registered read data returned to the winner
- done0  out  1  one-cycle completion pulse, port 0
- done1  out  1  one-cycle completion pulse, port 1

## Operation
- FSM states are IDLE, BUSY and DONE. A last-grant register `last` records which port was granted most recently.
- IDLE:
  - Only req0 high: grant port 0.
  - Only req1 high: grant port 1.
  - Both high: grant the port that is not `last` (round-robin).
  - On a grant, register sel = winner, update `last` = winner, go to BUSY.
  - No request: stay in IDLE.
- BUSY:
  - mem_en = 1.
  - sel is frozen.
  - Wait for mem_ready.
  - When mem_ready = 1, register rd <= mem_rd (including on stores; the value is don't-care to the requester) and go to DONE.
- DONE:
  - mem_en = 0.
  - done[sel] = 1 for exactly one cycle.
  - rd is held.
  - Go to IDLE.
- rd holds its value until the next completion.
- sel holds its value through IDLE until the next grant.
- A requester deasserts req by the edge ending its DONE cycle. A req still high in the following IDLE cycle is a new access.
- Requests that arrive during BUSY/DONE wait. There is no preemption.
- Reset values: state = IDLE, sel = 0, last = 1 (fetch wins the first tie), mem_en = 0, done0 = done1 = 0, rd = 0.
- Reset during BUSY or DONE aborts the access:
  - mem_en = 0 on the next cycle.
  - No done pulse is issued.
  - The requester must re-issue.

## Timing
- Request seen in IDLE at cycle N: BUSY from N+1, so mem_en is first high at N+1.
- mem_ready sampled high at cycle M: done and rd are valid at M+1, and IDLE is at M+2.
- Minimum access with mem_ready tied high is 3 cycles from grant to the next grant (IDLE, BUSY, DONE). Back-to-back accesses alternate when both ports are requesting continuously.
- mem_ready is ignored outside BUSY.
- done0 and done1 are never high in the same cycle.
- mem_we is never high while sel = 0.

## Test plan
- Reset, then fetch alone: assert rst 2 cycles. Check all outputs are 0 and sel = 0. Then req0 = 1, addr0 = 0x0000_0040, mem_ready = 1 with mem_rd = 0x2008_0005. Required: mem_en high 1 cycle with mem_addr = 0x40; the next cycle done0 = 1 and rd = 0x2008_0005.
- Store: req1 = 1, addr1 = 0x1000_0000, we1 = 1, wd1 = 0xDEAD_BEEF, with mem_ready delayed 3 cycles. Required: mem_en and mem_we high for 4 cycles, sel = 1, mem_wd = 0xDEAD_BEEF, then a single done1 pulse.
- Simultaneous requests after reset: req0 = req1 = 1 held. Required grant order is 0, 1, 0, 1, with done pulses alternating and never coincident.
- Held request: req1 kept high after done1 with req0 low. Required: a second data access starts on the following IDLE cycle.
- Reset mid-access: rst during BUSY with mem_ready = 0. Required: mem_en = 0 the next cycle, no done pulse, and state IDLE.
- Stall robustness: mem_ready toggling outside BUSY. Required: no state change and no done pulse.
